vga_capture: RTL and testbench
==============================

# vga_capture

Video-input receiver: the sink end of the team's VGA-style pixel interface (HS/VS/BLANK_N/RGB at a pixel strobe). It measures incoming timing, checks it against the expected active geometry, and writes each active pixel into a 24-bit framebuffer write port. It is the write-side counterpart to the scan-out generator that reads the same 200x600 framebuffer.

## Interface
Parameters:
- H_ACTIVE, 200, active pixels per line
- V_ACTIVE, 600, active lines per frame
- ADDR_W, 17, framebuffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
- CLOCK_50  input  1  system clock; the only clock
- RESET  input  1  synchronous, active-high reset
- pix_en  input  1  pixel strobe; all video inputs are sampled only on cycles where pix_en=1
- vid_hs  input  1  horizontal sync, active high
- vid_vs  input  1  vertical sync, active high
- vid_blank_n  input  1  1 = active pixel
- vid_r, vid_g, vid_b  input  8 each  pixel colour
- enable  input  1  capture request, sampled at frame boundaries
- fb_we  output  1  framebuffer write strobe
- fb_addr  output  ADDR_W  write address = line*H_ACTIVE + x
- fb_wdata  output  24  {r,g,b}
- frame_done  output  1  one-cycle pulse, good frame captured
- err  output  1  one-cycle pulse, geometry error
- locked  output  1  timing stable
- h_total  output  10  last measured pixel strobes per line
- v_total  output  10  last measured lines per frame

## Operation
- Sampling: a "sample" is a CLOCK_50 cycle with pix_en=1. Edges of vid_hs/vid_vs are detected by comparing with the previous sample's value; non-sample cycles change no state.
- Measurement (always running, independent of state): hcnt counts samples; on HS rising edge, h_total<=hcnt, hcnt<=1. vcnt counts HS rising edges; on VS rising edge, v_total<=vcnt, vcnt<=0. Both counters saturate at 1023.
- States: SEEK, CAPTURE.
  - SEEK: no writes. On VS rising edge with enable=1 -> CAPTURE, x<=0, line<=0.
  - CAPTURE: each sample with vid_blank_n=1 and x<H_ACTIVE and line<V_ACTIVE writes a pixel, x++. Active samples with x>=H_ACTIVE or line>=V_ACTIVE write nothing but mark a line error.
  - HS rising edge in CAPTURE: if x=0, ignore (blank line). If x=H_ACTIVE and no line error, line++, x<=0. Otherwise: err pulse, locked<=0, -> SEEK.
  - VS rising edge in CAPTURE: if line=V_ACTIVE, pulse frame_done; otherwise pulse err, set locked<=0. Then restart capture (x<=0, line<=0, stay in CAPTURE) if enable=1, else -> SEEK.
- HS and VS rising on the same sample: HS is processed first, then VS.
- Lock: locked<=1 at the second consecutive frame_done whose h_total and v_total equal those of the previous good frame. Any err clears locked and the good-frame history.
- Deasserting enable mid-frame does not abort the frame; it takes effect at the next VS rising edge.

## Timing
- fb_we, fb_addr, fb_wdata are registered: asserted exactly one CLOCK_50 cycle after the sample that produced them. fb_we is high for exactly one cycle per written pixel.
- frame_done and err are asserted one cycle after the triggering sample, for one cycle.
- No backpressure: the framebuffer must accept one write per cycle.
- Reset values: state SEEK, fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, err=0, locked=0, h_total=0, v_total=0, all internal counters 0, sync history 0. RESET mid-frame takes effect on the next edge, drops any pending write, and requires a fresh VS edge before any further write.

## Test plan
- Nominal timing (264 strobes/line, hsync on strobes 210-241, 628 lines, vsync on lines 601-604, pix_en every 5th cycle, enable=1) -> 120000 writes per frame at addresses 0..119999 in order; frame_done every frame; h_total=264, v_total=628; locked=1 one cycle after the 3rd VS edge.
- A known pattern with RGB = {x[7:0], line[7:0], 8'hA5} -> fb_wdata at address 201 equals 24'h0101A5.
- Line 10 carries only 199 active pixels -> err pulse at that HS edge; locked=0; no writes until the next VS; the following two frames relock.
- Line carries 201 active pixels -> no write at x=200 and no address beyond line*200+199; err pulse.
- pix_en held low for 7 cycles while vid_hs toggles -> no edge detected and the counters are unchanged.
- RESET pulsed mid-line during CAPTURE -> all outputs return to their reset values the next cycle; no write occurs until the following VS edge; enable=0 at that VS -> no writes at all.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: sink end of the VGA-style pixel interface. Measures sync timing,
// checks the active geometry and streams each active pixel into a framebuffer write port.
module vga_capture #(
    parameter int H_ACTIVE = 200,
    parameter int V_ACTIVE = 600,
    parameter int ADDR_W   = 17
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              pix_en,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              vid_blank_n,
    input  logic [7:0]        vid_r,
    input  logic [7:0]        vid_g,
    input  logic [7:0]        vid_b,
    input  logic              enable,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              frame_done,
    output logic              err,
    output logic              locked,
    output logic [9:0]        h_total,
    output logic [9:0]        v_total
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_FULL  = XW'(H_ACTIVE);
    localparam logic [LW-1:0] L_FULL  = LW'(V_ACTIVE);
    localparam logic [9:0]    CNT_MAX = 10'd1023;

    typedef enum logic [0:0] {SEEK = 1'b0, CAPTURE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]        h_total_q, h_total_d, v_total_q, v_total_d;
    logic [XW-1:0]     x_q, x_d;
    logic [LW-1:0]     line_q, line_d;
    logic              line_err_q, line_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [23:0]       fb_wdata_q, fb_wdata_d;
    logic              frame_done_q, frame_done_d, err_q, err_d;
    logic              locked_q, locked_d, have_good_q, have_good_d;
    logic [9:0]        good_h_q, good_h_d, good_v_q, good_v_d;

    logic          hs_rise_s, vs_rise_s, in_capture_s, active_px_s, px_in_range_s, px_write_s;
    logic          line_err_px_s, hs_cap_s, hs_blank_s, hs_good_s, hs_bad_s;
    logic          vs_cap_s, frame_good_s, frame_bad_s;
    logic [XW-1:0] x_px_s;
    logic [LW-1:0] line_hs_s;
    logic [9:0]    vcnt_hs_s;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + 10'd1;
        end
    endfunction

    // Within one sample the pixel is handled first, then HS, then VS.
    assign hs_rise_s     = pix_en & vid_hs & ~hs_prev_q;
    assign vs_rise_s     = pix_en & vid_vs & ~vs_prev_q;
    assign in_capture_s  = (state_q == CAPTURE);
    assign active_px_s   = pix_en & vid_blank_n & in_capture_s;
    assign px_in_range_s = (x_q < X_FULL) && (line_q < L_FULL);
    assign px_write_s    = active_px_s & px_in_range_s;
    assign line_err_px_s = line_err_q | (active_px_s & ~px_in_range_s);
    assign x_px_s        = px_write_s ? (x_q + XW'(1)) : x_q;
    assign hs_cap_s      = hs_rise_s & in_capture_s;
    assign hs_blank_s    = hs_cap_s & (x_px_s == {XW{1'b0}});
    assign hs_good_s     = hs_cap_s & (x_px_s == X_FULL) & ~line_err_px_s;
    assign hs_bad_s      = hs_cap_s & ~hs_blank_s & ~hs_good_s;
    assign line_hs_s     = hs_good_s ? (line_q + LW'(1)) : line_q;
    assign vs_cap_s      = vs_rise_s & in_capture_s & ~hs_bad_s;
    assign frame_good_s  = vs_cap_s & (line_hs_s == L_FULL);
    assign frame_bad_s   = vs_cap_s & (line_hs_s != L_FULL);
    assign vcnt_hs_s     = hs_rise_s ? sat_inc(vcnt_q) : vcnt_q;

    // State register and all other flops.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= SEEK;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= 10'd0;
            vcnt_q       <= 10'd0;
            h_total_q    <= 10'd0;
            v_total_q    <= 10'd0;
            x_q          <= {XW{1'b0}};
            line_q       <= {LW{1'b0}};
            line_err_q   <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            fb_we_q      <= 1'b0;
            fb_addr_q    <= {ADDR_W{1'b0}};
            fb_wdata_q   <= 24'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            have_good_q  <= 1'b0;
            good_h_q     <= 10'd0;
            good_v_q     <= 10'd0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            x_q          <= x_d;
            line_q       <= line_d;
            line_err_q   <= line_err_d;
            wr_addr_q    <= wr_addr_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            have_good_q  <= have_good_d;
            good_h_q     <= good_h_d;
            good_v_q     <= good_v_d;
        end
    end

    // Next state: a bad line drops to SEEK; every VS edge re-decides from enable.
    always_comb begin
        state_d = state_q;
        if (vs_rise_s) begin
            if (enable) begin
                state_d = CAPTURE;
            end else begin
                state_d = SEEK;
            end
        end else if (hs_bad_s) begin
            state_d = SEEK;
        end else begin
            state_d = state_q;
        end
    end

    // Free-running timing measurement; only sample cycles change it.
    always_comb begin
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        if (pix_en) begin
            hs_prev_d = vid_hs;
            vs_prev_d = vid_vs;
            if (hs_rise_s) begin
                h_total_d = hcnt_q;
                hcnt_d    = 10'd1;
            end else begin
                hcnt_d    = sat_inc(hcnt_q);
            end
            if (vs_rise_s) begin
                v_total_d = vcnt_hs_s;
                vcnt_d    = 10'd0;
            end else begin
                vcnt_d    = vcnt_hs_s;
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Pixel position tracking; the write address advances with every written pixel.
    always_comb begin
        x_d        = x_q;
        line_d     = line_q;
        line_err_d = line_err_q;
        wr_addr_d  = px_write_s ? (wr_addr_q + ADDR_W'(1)) : wr_addr_q;
        if (vs_rise_s) begin
            x_d        = {XW{1'b0}};
            line_d     = {LW{1'b0}};
            line_err_d = 1'b0;
            wr_addr_d  = {ADDR_W{1'b0}};
        end else if (hs_good_s || hs_bad_s) begin
            x_d        = {XW{1'b0}};
            line_d     = line_hs_s;
            line_err_d = 1'b0;
        end else if (in_capture_s) begin
            x_d        = x_px_s;
            line_err_d = line_err_px_s;
        end else begin
            x_d        = x_q;
        end
    end

    // Output comb: write port, status pulses and lock tracking.
    always_comb begin
        fb_we_d      = px_write_s;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        frame_done_d = frame_good_s;
        err_d        = hs_bad_s | frame_bad_s;
        locked_d     = locked_q;
        have_good_d  = have_good_q;
        good_h_d     = good_h_q;
        good_v_d     = good_v_q;
        if (px_write_s) begin
            fb_addr_d  = wr_addr_q;
            fb_wdata_d = {vid_r, vid_g, vid_b};
        end else begin
            fb_addr_d  = fb_addr_q;
        end
        if (err_d) begin
            locked_d    = 1'b0;
            have_good_d = 1'b0;
        end else if (frame_good_s) begin
            if (have_good_q && (h_total_d == good_h_q) && (v_total_d == good_v_q)) begin
                locked_d = 1'b1;
            end else begin
                locked_d = locked_q;
            end
            have_good_d = 1'b1;
            good_h_d    = h_total_d;
            good_v_d    = v_total_d;
        end else begin
            locked_d = locked_q;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunken 8x6 raster (12 strobes/line, 9 lines/frame) with
// random pixel-strobe gaps, random pixel data and a frame-level reference model.
module tb_vga_capture;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int AW = 6;
    localparam int HT = 12;
    localparam int VT = 9;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          pe   = 1'b0;
    logic          hs   = 1'b0;
    logic          vs   = 1'b0;
    logic          bl_n = 1'b0;
    logic          en   = 1'b0;
    logic [7:0]    r = 8'd0, g = 8'd0, b = 8'd0;
    logic          fb_we, frame_done, err, locked;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_wdata;
    logic [9:0]    h_total, v_total;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit cap_m, bad_m, prev_hs_m, prev_vs_m, locked_m, have_good_m;
    int hcnt_m, vcnt_m, htot_m, vtot_m, good_h_m, good_v_m, wr_seen;

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW)) dut (
        .CLOCK_50(clk), .RESET(rst), .pix_en(pe), .vid_hs(hs), .vid_vs(vs),
        .vid_blank_n(bl_n), .vid_r(r), .vid_g(g), .vid_b(b), .enable(en),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .frame_done(frame_done),
        .err(err), .locked(locked), .h_total(h_total), .v_total(v_total)
    );

    initial forever #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > 1023) ? 1023 : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cap_m = 0; bad_m = 0; prev_hs_m = 0; prev_vs_m = 0; locked_m = 0; have_good_m = 0;
        hcnt_m = 0; vcnt_m = 0; htot_m = 0; vtot_m = 0; good_h_m = 0; good_v_m = 0; wr_seen = 0;
    endtask

    task automatic tick(input bit p, input bit h, input bit v, input bit bn, input logic [23:0] rgb,
                        input bit exp_we, input int exp_addr, input bit exp_fd, input bit exp_err,
                        input bit pat);
        pe = p; hs = h; vs = v; bl_n = bn; {r, g, b} = rgb;
        @(posedge clk);
        #1;
        if (p) begin
            if (h && !prev_hs_m) begin
                htot_m = hcnt_m; hcnt_m = 1; vcnt_m = sat(vcnt_m + 1);
            end else begin
                hcnt_m = sat(hcnt_m + 1);
            end
            if (v && !prev_vs_m) begin
                vtot_m = vcnt_m; vcnt_m = 0;
            end
            prev_hs_m = h; prev_vs_m = v;
        end
        if (exp_fd) begin
            if (have_good_m && htot_m == good_h_m && vtot_m == good_v_m) locked_m = 1;
            have_good_m = 1; good_h_m = htot_m; good_v_m = vtot_m;
        end
        if (exp_err) begin
            locked_m = 0; have_good_m = 0;
        end
        if (fb_we === 1'b1) wr_seen++;
        chk("fb_we", fb_we, exp_we);
        if (exp_we) begin
            chk("fb_addr", fb_addr, exp_addr);
            chk("fb_wdata", fb_wdata, rgb);
            if (pat && exp_addr == HA + 1) chk("pattern_at_w_plus_1", fb_wdata, 32'h0001_01A5);
        end
        chk("frame_done", frame_done, exp_fd);
        chk("err", err, exp_err);
        chk("locked", locked, locked_m);
        chk("h_total", h_total, htot_m);
        chk("v_total", v_total, vtot_m);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom),
                 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_tick(input bit h, input bit v, input bit bn, input logic [23:0] rgb);
        rst = 1'b1; pe = 1'b1; hs = h; vs = v; bl_n = bn; {r, g, b} = rgb;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_h_total", h_total, 0);
        chk("rst_v_total", v_total, 0);
    endtask

    // One raster frame: va_n active lines (VS two lines later), an optional line with
    // bad_n active pixels, enable driven to en_vs from line 2, optional reset mid-line.
    task automatic send_frame(input int va_n, input int bad_line, input int bad_n,
                              input bit en_vs, input int rst_line, input bit pat);
        int n;
        bit h, v, act, we, fd, er;
        logic [23:0] rgb;
        for (int L = 0; L < VT; L++) begin
            if (L == 2) en = en_vs;
            for (int p = 0; p < HT; p++) begin
                n   = (L >= va_n) ? 0 : ((L == bad_line) ? bad_n : HA);
                h   = (p == HA + 1) || (p == HA + 2);
                v   = (L == va_n + 1) || (L == va_n + 2);
                act = (p < n);
                rgb = pat ? {8'(p), 8'(L), 8'hA5} : 24'($urandom);
                idle(int'($urandom_range(2)));
                if (L == rst_line && p == 3) begin
                    reset_tick(h, v, act, rgb);
                    continue;
                end
                we = act && cap_m && !bad_m && (p < HA);
                fd = 1'b0;
                er = 1'b0;
                if (p == HA + 1 && L < va_n && cap_m && !bad_m && n != HA) begin
                    er = 1'b1; bad_m = 1'b1;
                end
                if (p == 0 && L == va_n + 1) begin
                    if (cap_m && !bad_m) begin
                        if (va_n == VA) fd = 1'b1; else er = 1'b1;
                    end
                    cap_m = en; bad_m = 1'b0;
                end
                tick(1'b1, h, v, act, rgb, we, L * HA + p, fd, er, pat);
                if (p == 0 && L == va_n + 1) begin
                    if (fd) chk("frame_write_count", wr_seen, HA * VA);
                    wr_seen = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("reset_fb_addr", fb_addr, 0);
        chk("reset_fb_wdata", fb_wdata, 0);
        rst = 1'b0;
        en  = 1'b1;
        // acquisition and lock, pattern frames first
        send_frame(VA, -1, 0, 1'b1, -1, 1'b1);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b1);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        chk("h_total_nominal", h_total, HT);
        chk("v_total_nominal", v_total, VT);
        chk("locked_nominal", locked, 1);
        // short line, then relock
        send_frame(VA, 2, HA - 1, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        // long line, then relock
        send_frame(VA, 3, HA + 1, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        // sync toggling while pix_en is low must be invisible
        for (int i = 0; i < 7; i++)
            tick(1'b0, (i % 2 == 0), (i % 3 == 0), 1'b1, 24'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // too few lines before VS
        send_frame(4, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        // enable dropped mid-frame: this frame completes, the next is skipped
        send_frame(VA, -1, 0, 1'b0, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        // reset mid-line while capturing, enable low at the following VS
        send_frame(VA, -1, 0, 1'b0, 3, 1'b0);
        send_frame(VA, -1, 0, 1'b0, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        send_frame(VA, -1, 0, 1'b1, -1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
